// File: rtl/seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan : four-digit seven-segment scan driver with prescaled refresh    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seg_scan #(
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  an,
  output logic [6:0]  aa,
  output logic [6:0]  bb,
  output logic [6:0]  cc,
  output logic [6:0]  dd,
  output logic        frame_done
);

  localparam logic [6:0] C_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_D0  = 3'd1,
    ST_D1  = 3'd2,
    ST_D2  = 3'd3,
    ST_D3  = 3'd4
  } state_t;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [15:0]          value_q, value_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  state_t               state_q, state_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           aa_q, aa_d, bb_q, bb_d, cc_q, cc_d, dd_q, dd_d;
  logic                 frame_done_q, frame_done_d;
  logic                 tick;

  assign tick = (div_q == {DIV_WIDTH{1'b1}});

  always_comb begin
    value_d = load ? value : value_q;
    div_d   = div_q + DIV_WIDTH'(1);

    // Segments decode the currently held value, so a load shows one edge later.
    aa_d = blank_mask[3] ? C_BLANK : dec(value_q[15:12]);
    bb_d = blank_mask[2] ? C_BLANK : dec(value_q[11:8]);
    cc_d = blank_mask[1] ? C_BLANK : dec(value_q[7:4]);
    dd_d = blank_mask[0] ? C_BLANK : dec(value_q[3:0]);

    state_d      = state_q;
    frame_done_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_OFF: state_d = ST_D0;
        ST_D0:  state_d = ST_D1;
        ST_D1:  state_d = ST_D2;
        ST_D2:  state_d = ST_D3;
        ST_D3: begin
          state_d      = ST_D0;
          frame_done_d = 1'b1;
        end
        default: state_d = ST_D0;
      endcase
    end

    case (state_d)
      ST_D0:   an_d = 4'b1110;
      ST_D1:   an_d = 4'b1101;
      ST_D2:   an_d = 4'b1011;
      ST_D3:   an_d = 4'b0111;
      default: an_d = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q      <= '0;
      div_q        <= '0;
      state_q      <= ST_OFF;
      an_q         <= 4'b1111;
      aa_q         <= C_BLANK;
      bb_q         <= C_BLANK;
      cc_q         <= C_BLANK;
      dd_q         <= C_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      div_q        <= div_d;
      state_q      <= state_d;
      an_q         <= an_d;
      aa_q         <= aa_d;
      bb_q         <= bb_d;
      cc_q         <= cc_d;
      dd_q         <= dd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign aa         = aa_q;
  assign bb         = bb_q;
  assign cc         = cc_q;
  assign dd         = dd_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan : randomized bench for seg_scan against a behavioural model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_seg_scan;

  localparam int DW   = 2;
  localparam int DWELL = 1 << DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  an;
  logic [6:0]  aa, bb, cc, dd;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan #(.DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .blank_mask(blank_mask), .an(an), .aa(aa), .bb(bb), .cc(cc), .dd(dd),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_code [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model: k counts edges since reset release; the scan position follows from k alone.
  int         mk = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg [4];
  logic        exp_fd = 1'b0;

  initial begin
    for (int d = 0; d < 4; d++) exp_seg[d] = 7'h7F;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mk = 0;
        m_val = 16'h0;
        exp_an = 4'hF;
        exp_fd = 1'b0;
        for (int d = 0; d < 4; d++) exp_seg[d] = 7'h7F;
      end else begin
        for (int d = 0; d < 4; d++) begin
          logic [3:0] nib;
          nib = 4'((m_val >> (12 - 4 * d)) & 16'hF);
          exp_seg[d] = blank_mask[3 - d] ? 7'h7F : seg_code[nib];
        end
        if (load) m_val = value;
        mk++;
        if (mk < DWELL) begin
          exp_an = 4'hF;
        end else begin
          exp_an = ~(4'b0001 << ((mk / DWELL - 1) % 4));
        end
        exp_fd = (mk >= 5 * DWELL) && (mk % (4 * DWELL) == DWELL);
      end
      #1;
      chk("an", {28'h0, an}, {28'h0, exp_an});
      chk("aa", {25'h0, aa}, {25'h0, exp_seg[0]});
      chk("bb", {25'h0, bb}, {25'h0, exp_seg[1]});
      chk("cc", {25'h0, cc}, {25'h0, exp_seg[2]});
      chk("dd", {25'h0, dd}, {25'h0, exp_seg[3]});
      chk("frame_done", {31'h0, frame_done}, {31'h0, exp_fd});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] an_before;
    bit found;

    // Reset held for three cycles.
    repeat (3) after_edge();
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_aa", {25'h0, aa}, 32'h7F);
    chk("rst_fd", {31'h0, frame_done}, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (3) after_edge();
    chk("pre_first_tick_an", {28'h0, an}, 32'hF);
    after_edge();
    chk("first_tick_an", {28'h0, an}, 32'hE);

    // Rotation through to the first frame_done (edge 20 after release).
    repeat (16) after_edge();
    chk("frame_an", {28'h0, an}, 32'hE);
    chk("frame_pulse", {31'h0, frame_done}, 32'h1);

    // Decode 12AF.
    step();
    load = 1'b1; value = 16'h12AF;
    step();
    load = 1'b0;
    @(posedge clk); #2;
    chk("dec_aa", {25'h0, aa}, {25'h0, 7'b1001111});
    chk("dec_bb", {25'h0, bb}, {25'h0, 7'b0010010});
    chk("dec_cc", {25'h0, cc}, {25'h0, 7'b0001000});
    chk("dec_dd", {25'h0, dd}, {25'h0, 7'b0111000});

    // Blanking over 8888.
    step();
    load = 1'b1; value = 16'h8888; blank_mask = 4'b0101;
    step();
    load = 1'b0;
    @(posedge clk); #2;
    chk("blank_aa", {25'h0, aa}, 32'h00);
    chk("blank_bb", {25'h0, bb}, 32'h7F);
    chk("blank_cc", {25'h0, cc}, 32'h00);
    chk("blank_dd", {25'h0, dd}, 32'h7F);
    step();
    blank_mask = 4'b0000;

    // Load 0000 on a tick edge.
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (mk % DWELL == DWELL - 1) found = 1;
      else step();
    end
    chk("tick_found", {31'h0, found}, 32'h1);
    an_before = an;
    load = 1'b1; value = 16'h0000;
    after_edge();
    checks++;
    if (an === an_before) begin
      errors++;
      $display("FAIL tick_load_an actual=%h required=advance_from_%h", an, an_before);
    end
    step();
    load = 1'b0;
    @(posedge clk); #2;
    chk("zero_aa", {25'h0, aa}, 32'h01);
    chk("zero_dd", {25'h0, dd}, 32'h01);

    // Reset while digit 2 is selected.
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (exp_an == 4'b1011 && an == 4'b1011) found = 1;
    end
    chk("d2_found", {31'h0, found}, 32'h1);
    rst_n = 1'b0;
    after_edge();
    chk("midrst_an", {28'h0, an}, 32'hF);
    chk("midrst_aa", {25'h0, aa}, 32'h7F);
    chk("midrst_fd", {31'h0, frame_done}, 32'h0);
    step();
    rst_n = 1'b1;

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      load       = ($urandom_range(3) == 0);
      value      = 16'($urandom);
      blank_mask = ($urandom_range(4) == 0) ? 4'($urandom) : 4'h0;
      rst_n      = ($urandom_range(299) != 0);
    end
    step();
    rst_n = 1'b1; load = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
